// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-lane RAM plus LED/CYCLE/FADDR/STATUS MMIO, with a sticky access-fault flag.
// Latency: loads are combinational in the request cycle, and stores commit at the closing clock edge.
// Backpressure: none; every request is accepted in its own cycle, and faulting requests are dropped.
module data_mem_responder #(
    parameter int AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_w,
    input  logic        mem_r,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  dm_type,
    output logic [31:0] rdata,
    output logic [15:0] led,
    output logic        fault
);
    logic [31:0] ram [0:(1<<AW)-1];

    logic [31:0] led_reg;
    logic [31:0] cycle_cnt;
    logic [31:0] faddr;
    logic        fault_q;

    logic          is_word, is_half, is_byte, type_ok;
    logic          in_ram, in_mmio, misalign, bad;
    logic          ok_rd, ok_wr;
    logic [AW-1:0] word_idx;
    logic [31:0]   rword, wlane;
    logic [3:0]    wmask;
    logic [7:0]    sel_b;
    logic [15:0]   sel_h;

    assign is_word  = (dm_type == 3'b000);
    assign is_half  = (dm_type == 3'b001) || (dm_type == 3'b010);
    assign is_byte  = (dm_type == 3'b011) || (dm_type == 3'b100);
    assign type_ok  = is_word || is_half || is_byte;
    assign in_ram   = (addr[31:AW+2] == '0);
    assign in_mmio  = (addr[31:4] == 28'hFFFF000);
    assign misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));

    // Any single violation kills the access; a simultaneous read+write is itself a violation.
    assign bad = (mem_w || mem_r) &&
                 (!type_ok || misalign || !(in_ram || in_mmio) ||
                  (in_mmio && !is_word) || (mem_w && mem_r));

    assign ok_rd    = mem_r && !bad && !reset;
    assign ok_wr    = mem_w && !bad && !reset;
    assign word_idx = addr[AW+1:2];
    assign rword    = ram[word_idx];
    assign sel_b    = rword[{addr[1:0], 3'b000} +: 8];
    assign sel_h    = addr[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        rdata = 32'h0;
        if (ok_rd) begin
            if (in_mmio) begin
                case (addr[3:2])
                    2'd0:    rdata = led_reg;
                    2'd1:    rdata = cycle_cnt;
                    2'd2:    rdata = faddr;
                    default: rdata = {31'b0, fault_q};
                endcase
            end else begin
                case (dm_type)
                    3'b000:  rdata = rword;
                    3'b001:  rdata = {{16{sel_h[15]}}, sel_h};
                    3'b010:  rdata = {16'h0, sel_h};
                    3'b011:  rdata = {{24{sel_b[7]}}, sel_b};
                    default: rdata = {24'h0, sel_b};
                endcase
            end
        end
    end

    always_comb begin
        wmask = 4'b0000;
        wlane = wdata;
        if (is_word) begin
            wmask = 4'b1111;
        end else if (is_half) begin
            wmask = addr[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wdata[15:0]}};
        end else begin
            wmask = 4'b0001 << addr[1:0];
            wlane = {4{wdata[7:0]}};
        end
    end

    // RAM has no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (ok_wr && in_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) ram[word_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_reg   <= 32'h0;
            cycle_cnt <= 32'h0;
            faddr     <= 32'h0;
            fault_q   <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (bad) begin
                fault_q <= 1'b1;
                if (!fault_q) faddr <= addr;
            end else if (ok_wr && in_mmio) begin
                // CYCLE and FADDR are read-only; writes to them are silently dropped.
                case (addr[3:2])
                    2'd0:    led_reg <= wdata;
                    2'd3:    if (wdata[0]) fault_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign led   = led_reg[15:0];
    assign fault = fault_q;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter AW, default 10, log2 of RAM depth in 32-bit words; RAM byte range 0 .. 4*2^AW-1.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 mem_w  input  1  store request for the current cycle.
REQ-005 mem_r  input  1  load request for the current cycle.
REQ-006 addr  input  32  byte address.
REQ-007 wdata  input  32  store data, right-aligned.
REQ-008 dm_type  input  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; other values are illegal.
REQ-009 rdata  output  32  load data, combinational from the same-cycle request.
REQ-010 led  output  16  LED register bits [15:0].
REQ-011 fault  output  1  sticky access-fault flag.

Function
REQ-012 The memory map SHALL be as follows:
- RAM at 0 .. 4*2^AW-1.
- MMIO at 0xFFFF0000 LED (RW), 0xFFFF0004 CYCLE (RO), 0xFFFF0008 FADDR (RO), 0xFFFF000C STATUS (bit0 = fault, write-1-to-clear).
- Every other address is unmapped.
REQ-013 Loads SHALL be zero-latency: rdata is valid in the cycle mem_r is high, for capture by the requester at the next rising edge.
REQ-014 A store SHALL commit at the rising edge ending the cycle in which mem_w is high.
REQ-015 Stores SHALL write byte lanes only:
- byte: lane addr[1:0] = wdata[7:0].
- half: lanes {addr[1],0} and {addr[1],1} = wdata[15:0].
- word: all four lanes.
- Other lanes are unchanged.
REQ-016 Loads SHALL select the addressed byte or half and sign- or zero-extend it per dm_type.
REQ-017 An access SHALL be a fault if any of the following holds:
- halfword with addr[0]=1.
- word with addr[1:0]!=0.
- illegal dm_type.
- unmapped address.
- MMIO access that is not a word access.
- mem_w and mem_r both high.
REQ-018 On a faulting access:
- Stores are suppressed.
- rdata = 0.
- fault is set at the next edge.
- FADDR captures addr only if fault was 0 before that edge.
REQ-019 When mem_r is low, rdata SHALL be 0.
REQ-020 CYCLE SHALL increment by 1 every cycle not in reset and wrap from 0xFFFFFFFF to 0.
REQ-021 A store to CYCLE or FADDR SHALL be ignored and SHALL not be a fault.
REQ-022 A word store to STATUS with wdata[0]=1 SHALL clear fault. A new fault in the same cycle SHALL take priority, so fault stays 1.
REQ-023 A word load of STATUS SHALL return {31'b0, fault}. LED and FADDR SHALL read back their full 32-bit values.
REQ-024 The RAM SHALL be a single port, so no read and write can occur in the same cycle. A load in the cycle after a store SHALL return the newly stored data.

Reset
REQ-025 While reset is high, the following SHALL be set at the next edge:
- LED, CYCLE, FADDR and fault = 0.
- led = 0.
- rdata = 0.
- Any requested store is suppressed.
REQ-026 RAM contents SHALL NOT be cleared by reset and SHALL retain their values across reset.
REQ-027 Reset asserted in the same cycle as a store SHALL discard the store. Reset asserted while fault = 1 SHALL clear fault.

Verification
REQ-028 Word and byte round-trip: store word 0x80FF7F01 @0x10, then load byte-signed @0x11 -> 0x0000007F; load byte-signed @0x13 -> 0xFFFFFF80; load byte-unsigned @0x12 -> 0x000000FF; load word @0x10 -> 0x80FF7F01.
REQ-029 Half-word merge: store word 0x11223344 @0x20, then store half 0xABCD @0x22, then load word @0x20 -> 0xABCD3344; load half-signed @0x22 -> 0xFFFFABCD; load half-unsigned -> 0x0000ABCD.
REQ-030 Fault capture and clear: store word @0x06 -> RAM unchanged, fault=1, FADDR=0x00000006. A second fault @0x4000_0000 leaves FADDR=0x00000006. Store 0x1 @0xFFFF000C -> fault=0. A clear with a simultaneous fault -> fault=1.
REQ-031 MMIO and reset: store 0x0001ABCD @0xFFFF0000 -> led=0xABCD. Store @0xFFFF0004 -> CYCLE continues counting, no fault. Byte load @0xFFFF0000 -> rdata=0, fault=1. Reset -> led=0, CYCLE=0 after the reset edge, then 1 after the next edge.
REQ-032 Wrap and conflict: force CYCLE to 0xFFFFFFFF (hierarchical deposit) -> next edge CYCLE=0. mem_w=mem_r=1 @0x30 -> RAM unchanged, rdata=0, fault=1.
